mux4_rr_sched: RTL and testbench
================================

Name: mux4_rr_sched

Overview:
- Round-robin scheduler that shares one 4:1 single-bit select path among four requesters.
- Arbitrates the requests, holds a registered 2-bit select (s1,s0) for the winner, and presents the selected bit on a valid/ready output stream.
- Limits each grant to a burst of BURST_MAX accepted beats, then re-arbitrates without a bubble.
- Sits between four bit-serial producers and one consumer.

Parameters:
BURST_MAX, 4, maximum accepted beats per grant before forced re-arbitration; legal range 1..255.
CW, $clog2(BURST_MAX+1), beat counter width; derived, not overridden.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  4  request per requester; bit i = requester i
din  input  4  data bit per requester; din[i] held stable while req[i]=1 and ack[i]=0
ack  output  4  one-hot; ack[i]=1 in the cycle a beat from requester i is accepted
grant  output  4  one-hot registered grant; 0 when idle
sel  output  2  registered select {s1,s0} = index of granted requester
out_valid  output  1  selected beat valid
out_ready  input  1  consumer accepts beat when high with out_valid
out_data  output  1  din[sel] when out_valid, else 0
busy  output  1  1 while in GRANT state

Behaviour:
- Reset (async assert, sync release): state=IDLE, grant=0, sel=0, ptr=3, cnt=0, busy=0. Combinational outputs then evaluate to out_valid=0, out_data=0, ack=0.
- Reset takes effect immediately regardless of state; any in-flight burst is discarded.
- ptr = index of the last granted requester. Reset value 3 gives requester 0 first priority.
- Round-robin pick: search req from ptr+1 upward, modulo 4. The first set bit wins.
- IDLE:
  - If req != 0: register winner into sel/grant, cnt<=0, go to GRANT.
  - Latency: req rising in cycle N gives out_valid in cycle N+1.
  - If req == 0: stay IDLE.
- GRANT:
  - out_valid = req[sel] (combinational). out_data = din[sel] & out_valid.
  - Beat accepted when out_valid & out_ready. ack[sel]=1 that cycle (combinational), and cnt increments.
  - Release occurs in either of two cases:
    - a beat is accepted while cnt == BURST_MAX-1;
    - req[sel]==0 (requester withdrew). No beat and no ack in this case.
  - On release:
    - ptr<=sel, cnt<=0.
    - Re-arbitrate in the same cycle using the current req, searching from sel+1.
    - If any req is set: go to GRANT with the new winner, with no idle cycle.
    - Otherwise go to IDLE with grant=0.
  - A sole requester that is still requesting is regranted immediately after its burst.
  - Backpressure (out_valid=1, out_ready=0): grant, sel, cnt and out_data are all held. ack=0. No timeout.
- Simultaneous events:
  - Withdrawal takes priority over burst completion. If req[sel]=0, out_valid=0, so no accept is possible.
  - New requests arriving mid-burst never preempt the current grant.
- sel and grant always change together on a clock edge, and grant==(1<<sel) whenever busy=1.
- cnt never exceeds BURST_MAX-1. With BURST_MAX=1 every accepted beat releases.

Test Plan:
- Reset, then req=0001, out_ready=1, BURST_MAX=4 -> cycle after req: sel=00, grant=0001, out_valid=1. Four acks on ack[0]. Then regrant of requester 0 with no idle cycle; busy stays 1.
- req=1111 held, out_ready=1, din=1010 -> grant order 0,1,2,3,0 with 4 beats each. out_data sequence 0000 1111 0000 1111 0000. Never an idle cycle.
- Granted requester 2, out_ready=0 for 5 cycles -> ack=0000, cnt frozen, sel=10 and out_data=din[2] stable. out_ready=1 resumes the remaining beats.
- Requester 1 granted, 2 beats accepted, then req[1] drops with req=0100 -> no ack that cycle, next cycle sel=10, grant=0100, cnt=0, ptr=1.
- rst_n pulsed low mid-burst (requester 3 active) -> grant/out_valid/ack go to 0 immediately. After release with req=1001, requester 0 wins first.
- BURST_MAX=1, req=0101, out_ready=1 -> grants alternate 0,2,0,2, one ack per grant, back-to-back with no idle cycles.

Source files
------------

// File: rtl/mux4_rr_sched_if.sv
// Requester, select and output-stream signals shared by the scheduler and its neighbours.
// The slave view belongs to the scheduler; the master view belongs to the producers and consumer.
interface mux4_rr_sched_if;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] ack;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       out_valid;
    logic       out_ready;
    logic       out_data;
    logic       busy;

    modport slave (
        input  req, din, out_ready,
        output ack, grant, sel, out_valid, out_data, busy
    );

    modport master (
        output req, din, out_ready,
        input  ack, grant, sel, out_valid, out_data, busy
    );
endinterface

// File: rtl/mux4_rr_sched.sv
// Round-robin 4:1 bit-stream scheduler with a registered select; each grant is capped at BURST_MAX beats.
// Latency: a request reaches out_valid one cycle later; after a burst the re-grant follows with no bubble.
// Backpressure: out_ready low freezes grant, sel and the beat count and withholds ack; there is no timeout.
module mux4_rr_sched #(
    parameter int BURST_MAX = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mux4_rr_sched_if.slave bus
);
    localparam int CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_q, state_nxt;
    logic [1:0]    sel_q, sel_nxt;
    logic [1:0]    ptr_q, ptr_nxt;
    logic [3:0]    grant_q, grant_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;

    logic       busy;
    logic       out_valid;
    logic       accept;
    logic       withdrawn;
    logic       burst_done;
    logic [1:0] pick_base;
    logic [2:0] pick;

    // Returns {found, index}; the search begins one past base and wraps, so base itself is tried last.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd3;
            grant_q <= 4'b0000;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            sel_q   <= sel_nxt;
            ptr_q   <= ptr_nxt;
            grant_q <= grant_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        sel_nxt   = sel_q;
        ptr_nxt   = ptr_q;
        grant_nxt = grant_q;
        cnt_nxt   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick[2]) begin
                    state_nxt = GRANT;
                    sel_nxt   = pick[1:0];
                    grant_nxt = 4'b0001 << pick[1:0];
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                // Withdrawal and burst completion both release; a new winner is taken in the same cycle.
                if (withdrawn || burst_done) begin
                    ptr_nxt = sel_q;
                    cnt_nxt = '0;
                    if (pick[2]) begin
                        sel_nxt   = pick[1:0];
                        grant_nxt = 4'b0001 << pick[1:0];
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = 4'b0000;
                    end
                end else if (accept) begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        busy       = (state_q == GRANT);
        out_valid  = busy & bus.req[sel_q];
        withdrawn  = busy & ~bus.req[sel_q];
        accept     = out_valid & bus.out_ready;
        burst_done = accept & (cnt_q == CNT_LAST);
        pick_base  = busy ? sel_q : ptr_q;
        pick       = rr_pick(bus.req, pick_base);
    end

    assign bus.busy      = busy;
    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = bus.din[sel_q] & out_valid;
    assign bus.ack       = accept ? (4'b0001 << sel_q) : 4'b0000;
endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed bench for mux4_rr_sched: a BURST_MAX=4 instance on bus a and a BURST_MAX=1 instance on bus b.
// Expected beats are queued as stimulus is driven and retired against ack/out_data at each negedge.
module tb_mux4_rr_sched;
    typedef struct packed {
        logic [1:0] idx;
        logic       data;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst_n;
    int    total = 0;
    int    bad = 0;
    beat_t qa[$];
    beat_t qb[$];

    mux4_rr_sched_if a ();
    mux4_rr_sched_if b ();

    mux4_rr_sched #(.BURST_MAX(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(a));
    mux4_rr_sched #(.BURST_MAX(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic push_a(input logic [1:0] i, input logic d);
        beat_t e;
        e.idx  = i;
        e.data = d;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic [1:0] i, input logic d);
        beat_t e;
        e.idx  = i;
        e.data = d;
        qb.push_back(e);
    endtask

    // Waits for the falling edge and retires any accepted beat on either bus against its queue.
    task automatic obs();
        beat_t e;
        @(negedge clk);
        if (a.ack !== 4'b0000) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_ack", {4'b0000, a.ack}, 8'h00);
            end else begin
                e = qa.pop_front();
                chk("a_beat_ack", {4'b0000, a.ack}, 8'h01 << e.idx);
                chk("a_beat_data", {7'b0, a.out_data}, {7'b0, e.data});
            end
        end
        if (b.ack !== 4'b0000) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_ack", {4'b0000, b.ack}, 8'h00);
            end else begin
                e = qb.pop_front();
                chk("b_beat_ack", {4'b0000, b.ack}, 8'h01 << e.idx);
                chk("b_beat_data", {7'b0, b.out_data}, {7'b0, e.data});
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] gi;
        rst_n       = 1'b0;
        a.req       = 4'b0000;
        a.din       = 4'b0000;
        a.out_ready = 1'b0;
        b.req       = 4'b0000;
        b.din       = 4'b0000;
        b.out_ready = 1'b0;

        obs();
        chk("rst_grant", {4'b0, a.grant}, 8'h00);
        chk("rst_sel", {6'b0, a.sel}, 8'h00);
        chk("rst_busy", {7'b0, a.busy}, 8'h00);
        chk("rst_valid", {7'b0, a.out_valid}, 8'h00);
        chk("rst_data", {7'b0, a.out_data}, 8'h00);
        chk("rst_ack", {4'b0, a.ack}, 8'h00);
        chk("rst_b_grant", {4'b0, b.grant}, 8'h00);
        adv();
        rst_n = 1'b1;

        // Sole requester 0: four-beat burst, then immediate regrant with busy held high.
        a.req = 4'b0001; a.din = 4'b0001; a.out_ready = 1'b1;
        obs();
        chk("t1_idle_busy", {7'b0, a.busy}, 8'h00);
        chk("t1_idle_valid", {7'b0, a.out_valid}, 8'h00);
        adv();
        for (int k = 0; k < 5; k++) begin
            push_a(2'd0, 1'b1);
            obs();
            chk("t1_busy", {7'b0, a.busy}, 8'h01);
            chk("t1_grant", {4'b0, a.grant}, 8'h01);
            chk("t1_sel", {6'b0, a.sel}, 8'h00);
            chk("t1_valid", {7'b0, a.out_valid}, 8'h01);
            adv();
        end
        a.req = 4'b0000;
        obs();
        chk("t1_wd_ack", {4'b0, a.ack}, 8'h00);
        adv();
        obs();
        chk("t1_end_busy", {7'b0, a.busy}, 8'h00);
        chk("t1_end_grant", {4'b0, a.grant}, 8'h00);
        adv();

        rst_n = 1'b0;
        obs();
        adv();
        rst_n = 1'b1;

        // All four requesting: rotation 0,1,2,3,0 with four beats each and no gap.
        a.req = 4'b1111; a.din = 4'b1010; a.out_ready = 1'b1;
        obs();
        adv();
        for (int k = 0; k < 20; k++) begin
            gi = 2'((k / 4) % 4);
            push_a(gi, a.din[gi]);
            obs();
            chk("t2_grant", {4'b0, a.grant}, 8'h01 << gi);
            chk("t2_sel", {6'b0, a.sel}, {6'b0, gi});
            adv();
        end

        // Requester 1 withdraws in favour of 2; then one beat, five stalled cycles, three more beats.
        a.req = 4'b0100; a.din = 4'b0100; a.out_ready = 1'b0;
        obs();
        chk("t3_wd_ack", {4'b0, a.ack}, 8'h00);
        chk("t3_wd_valid", {7'b0, a.out_valid}, 8'h00);
        adv();
        a.req = 4'b0110; a.din = 4'b0110; a.out_ready = 1'b1;
        push_a(2'd2, 1'b1);
        obs();
        chk("t3_grant", {4'b0, a.grant}, 8'h04);
        chk("t3_sel", {6'b0, a.sel}, 8'h02);
        adv();
        a.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            obs();
            chk("t3_stall_ack", {4'b0, a.ack}, 8'h00);
            chk("t3_stall_sel", {6'b0, a.sel}, 8'h02);
            chk("t3_stall_data", {7'b0, a.out_data}, 8'h01);
            chk("t3_stall_valid", {7'b0, a.out_valid}, 8'h01);
            adv();
        end
        a.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push_a(2'd2, 1'b1);
            obs();
            chk("t3_resume_grant", {4'b0, a.grant}, 8'h04);
            adv();
        end

        // Requester 1 takes two beats then drops; requester 2 gets a fresh full burst.
        push_a(2'd1, 1'b1);
        obs();
        chk("t4_grant", {4'b0, a.grant}, 8'h02);
        chk("t4_sel", {6'b0, a.sel}, 8'h01);
        adv();
        push_a(2'd1, 1'b1);
        obs();
        adv();
        a.req = 4'b0100;
        obs();
        chk("t4_wd_ack", {4'b0, a.ack}, 8'h00);
        chk("t4_wd_valid", {7'b0, a.out_valid}, 8'h00);
        adv();
        a.req = 4'b0101; a.din = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            push_a(2'd2, 1'b1);
            obs();
            chk("t4_new_grant", {4'b0, a.grant}, 8'h04);
            chk("t4_new_sel", {6'b0, a.sel}, 8'h02);
            adv();
        end
        push_a(2'd0, 1'b1);
        obs();
        chk("t4_next_grant", {4'b0, a.grant}, 8'h01);
        adv();

        // Reset asserted mid-burst of requester 3; requester 0 must win after release.
        a.req = 4'b1000; a.din = 4'b1000;
        obs();
        chk("t5_wd_ack", {4'b0, a.ack}, 8'h00);
        adv();
        push_a(2'd3, 1'b1);
        obs();
        chk("t5_grant", {4'b0, a.grant}, 8'h08);
        adv();
        push_a(2'd3, 1'b1);
        obs();
        adv();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_grant", {4'b0, a.grant}, 8'h00);
        chk("t5_rst_valid", {7'b0, a.out_valid}, 8'h00);
        chk("t5_rst_ack", {4'b0, a.ack}, 8'h00);
        chk("t5_rst_busy", {7'b0, a.busy}, 8'h00);
        a.req = 4'b1001; a.din = 4'b1001;
        obs();
        adv();
        rst_n = 1'b1;
        obs();
        chk("t5_idle_busy", {7'b0, a.busy}, 8'h00);
        adv();
        push_a(2'd0, 1'b1);
        obs();
        chk("t5_first_grant", {4'b0, a.grant}, 8'h01);
        chk("t5_first_sel", {6'b0, a.sel}, 8'h00);
        adv();
        a.req = 4'b0000;
        obs();
        adv();
        obs();
        chk("t5_end_busy", {7'b0, a.busy}, 8'h00);
        adv();

        // Single-beat bursts: requesters 0 and 2 alternate every cycle.
        b.req = 4'b0101; b.din = 4'b0001; b.out_ready = 1'b1;
        obs();
        chk("t6_idle_busy", {7'b0, b.busy}, 8'h00);
        adv();
        for (int k = 0; k < 4; k++) begin
            gi = (k % 2 == 0) ? 2'd0 : 2'd2;
            push_b(gi, b.din[gi]);
            obs();
            chk("t6_grant", {4'b0, b.grant}, 8'h01 << gi);
            chk("t6_busy", {7'b0, b.busy}, 8'h01);
            adv();
        end
        b.req = 4'b0000;
        obs();
        adv();

        chk("a_beats_left", 8'(qa.size()), 8'h00);
        chk("b_beats_left", 8'(qb.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
